// File: rtl/checker_stream_arbiter.sv
// Two-channel message scheduler in front of a single cpu_checker.
// Each channel buffers characters in its own FIFO, and only messages ending in '#' are streamed to the checker.
module checker_stream_arbiter #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [7:0]  IDLE_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0_char,
  input  logic       in0_valid,
  output logic       in0_ready,
  input  logic [7:0] in1_char,
  input  logic       in1_valid,
  output logic       in1_ready,
  output logic [7:0] chk_char,
  input  logic [1:0] chk_format_type,
  input  logic [3:0] chk_error_code,
  output logic       res_valid,
  output logic       res_chan,
  output logic [1:0] res_format_type,
  output logic [3:0] res_error_code,
  output logic       ovf0,
  output logic       ovf1
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam logic [7:0]  HASH = 8'h23;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   capture_c;

  logic       res_valid_q, res_chan_q;
  logic [1:0] res_fmt_q;
  logic [3:0] res_err_q;

  logic [1:0][7:0] in_char_c, head_c;
  logic [1:0]      in_valid_c, ready_c, push_c, pop_c, flush_c, req_c, granted_c, ovf_c;

  assign in_char_c  = {in1_char, in0_char};
  assign in_valid_c = {in1_valid, in0_valid};

  // Per-channel FIFO, buffered-'#' counter and overflow flush
  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d, msg_q, msg_d;
    logic          ovf_q, inc, dec;

    assign head_c[g]    = mem_q[rd_q];
    assign ready_c[g]   = (cnt_q != CW'(DEPTH));
    assign granted_c[g] = (state_q == S_SEND) && (grant_q == 1'(g));
    assign pop_c[g]     = granted_c[g];
    // A full FIFO with no complete message can never drain, so it is discarded
    assign flush_c[g]   = !ready_c[g] && (msg_q == '0) && !granted_c[g];
    assign push_c[g]    = in_valid_c[g] && ready_c[g] && !flush_c[g];
    assign req_c[g]     = (msg_q != '0);
    assign ovf_c[g]     = ovf_q;

    assign inc   = push_c[g] && (in_char_c[g] == HASH);
    assign dec   = pop_c[g] && (head_c[g] == HASH);
    assign cnt_d = cnt_q + CW'(push_c[g]) - CW'(pop_c[g]);
    assign msg_d = msg_q + CW'(inc) - CW'(dec);

    always_ff @(posedge clk) begin
      if (push_c[g]) mem_q[wr_q] <= in_char_c[g];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        msg_q <= '0;
        ovf_q <= 1'b0;
      end else if (flush_c[g]) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        msg_q <= '0;
        ovf_q <= 1'b1;
      end else begin
        if (push_c[g]) wr_q <= wr_q + AW'(1);
        if (pop_c[g])  rd_q <= rd_q + AW'(1);
        cnt_q <= cnt_d;
        msg_q <= msg_d;
        ovf_q <= 1'b0;
      end
    end
  end

  // grant_q doubles as the round-robin pointer; resetting it to 1 favours channel 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    chk_char  = IDLE_CHAR;
    capture_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_c) begin
          state_d = S_SEND;
          grant_d = (&req_c) ? !grant_q : req_c[1];
        end
      end
      S_SEND: begin
        chk_char = head_c[grant_q];
        if (head_c[grant_q] == HASH) state_d = S_WAIT;
      end
      S_WAIT: begin
        capture_c = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Verdict capture; fields hold until the next message completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_chan_q  <= 1'b0;
      res_fmt_q   <= '0;
      res_err_q   <= '0;
    end else begin
      res_valid_q <= capture_c;
      if (capture_c) begin
        res_chan_q <= grant_q;
        res_fmt_q  <= chk_format_type;
        res_err_q  <= chk_error_code;
      end
    end
  end

  assign in0_ready       = ready_c[0];
  assign in1_ready       = ready_c[1];
  assign ovf0            = ovf_c[0];
  assign ovf1            = ovf_c[1];
  assign res_valid       = res_valid_q;
  assign res_chan        = res_chan_q;
  assign res_format_type = res_fmt_q;
  assign res_error_code  = res_err_q;

endmodule

// File: tb/tb_checker_stream_arbiter.sv
// Directed bench for checker_stream_arbiter; the checker verdict inputs are driven directly by the bench.
module tb_checker_stream_arbiter;

  localparam logic [7:0] IDLE = 8'h20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in0_char, in1_char, chk_char;
  logic       in0_valid, in1_valid, in0_ready, in1_ready;
  logic [1:0] chk_format_type, res_format_type;
  logic [3:0] chk_error_code, res_error_code;
  logic       res_valid, res_chan, ovf0, ovf1;

  int errors = 0;
  int checks = 0;

  checker_stream_arbiter #(.DEPTH(64), .IDLE_CHAR(8'h20)) dut (
    .clk(clk), .reset(reset),
    .in0_char(in0_char), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_char(in1_char), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .chk_char(chk_char), .chk_format_type(chk_format_type), .chk_error_code(chk_error_code),
    .res_valid(res_valid), .res_chan(res_chan), .res_format_type(res_format_type),
    .res_error_code(res_error_code), .ovf0(ovf0), .ovf1(ovf1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [7:0] c0;
    logic       v1;
    logic [7:0] c1;
    logic [1:0] f;
    logic [3:0] e;
    logic [7:0] x_chk;
    logic       x_rv;
    logic       x_rch;
    logic [1:0] x_rf;
    logic [3:0] x_re;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic v0, input logic [7:0] c0, input logic v1, input logic [7:0] c1,
                              input logic [1:0] f, input logic [3:0] e, input logic [7:0] x_chk,
                              input logic x_rv, input logic x_rch, input logic [1:0] x_rf, input logic [3:0] x_re);
    vec_t r;
    r.v0 = v0; r.c0 = c0; r.v1 = v1; r.c1 = c1; r.f = f; r.e = e;
    r.x_chk = x_chk; r.x_rv = x_rv; r.x_rch = x_rch; r.x_rf = x_rf; r.x_re = x_re;
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the edge; return at the following falling edge
  task automatic cyc(input logic v0, input logic [7:0] c0, input logic v1, input logic [7:0] c1,
                     input logic [1:0] f, input logic [3:0] e);
    @(posedge clk);
    #1;
    in0_valid = v0; in0_char = c0; in1_valid = v1; in1_char = c1;
    chk_format_type = f; chk_error_code = e;
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 2'b11, 4'hF);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  string      msg;
  logic [7:0] exp_s [11];

  initial begin
    reset = 1'b0;
    in0_valid = 1'b0; in0_char = 8'h00; in1_valid = 1'b0; in1_char = 8'h00;
    chk_format_type = 2'b11; chk_error_code = 4'hF;
    #1 reset = 1'b1;
    #2;
    check("rst_chk_char", chk_char, IDLE);
    check("rst_in0_ready", 8'(in0_ready), 8'h01);
    check("rst_in1_ready", 8'(in1_ready), 8'h01);
    check("rst_res_valid", 8'(res_valid), 8'h00);
    check("rst_res_fields", {1'b0, res_chan, res_format_type, res_error_code}, 8'h00);
    check("rst_ovf", {6'd0, ovf1, ovf0}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Short ch0 message then short ch1 message; verdict inputs are garbage outside WAIT
    tbl[0]  = mk(1, "a", 0, 0, 2'b11, 4'hF, IDLE, 0, 0, 2'b00, 4'h0);
    tbl[1]  = mk(1, "b", 0, 0, 2'b11, 4'hF, IDLE, 0, 0, 2'b00, 4'h0);
    tbl[2]  = mk(1, "#", 0, 0, 2'b11, 4'hF, IDLE, 0, 0, 2'b00, 4'h0);
    tbl[3]  = mk(0, 0,   0, 0, 2'b11, 4'hF, IDLE, 0, 0, 2'b00, 4'h0);
    tbl[4]  = mk(0, 0,   0, 0, 2'b11, 4'hF, "a",  0, 0, 2'b00, 4'h0);
    tbl[5]  = mk(0, 0,   0, 0, 2'b11, 4'hF, "b",  0, 0, 2'b00, 4'h0);
    tbl[6]  = mk(0, 0,   0, 0, 2'b11, 4'hF, "#",  0, 0, 2'b00, 4'h0);
    tbl[7]  = mk(0, 0,   0, 0, 2'b01, 4'h3, IDLE, 0, 0, 2'b00, 4'h0);
    tbl[8]  = mk(0, 0,   0, 0, 2'b11, 4'hF, IDLE, 1, 0, 2'b01, 4'h3);
    tbl[9]  = mk(0, 0,   1, "x", 2'b11, 4'hF, IDLE, 0, 0, 2'b01, 4'h3);
    tbl[10] = mk(0, 0,   1, "#", 2'b11, 4'hF, IDLE, 0, 0, 2'b01, 4'h3);
    tbl[11] = mk(0, 0,   0, 0, 2'b11, 4'hF, IDLE, 0, 0, 2'b01, 4'h3);
    tbl[12] = mk(0, 0,   0, 0, 2'b11, 4'hF, "x",  0, 0, 2'b01, 4'h3);
    tbl[13] = mk(0, 0,   0, 0, 2'b11, 4'hF, "#",  0, 0, 2'b01, 4'h3);
    tbl[14] = mk(0, 0,   0, 0, 2'b10, 4'h5, IDLE, 0, 0, 2'b01, 4'h3);
    tbl[15] = mk(0, 0,   0, 0, 2'b11, 4'hF, IDLE, 1, 1, 2'b10, 4'h5);
    tbl[16] = mk(0, 0,   0, 0, 2'b11, 4'hF, IDLE, 0, 1, 2'b10, 4'h5);
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].v0, tbl[i].c0, tbl[i].v1, tbl[i].c1, tbl[i].f, tbl[i].e);
      check($sformatf("tbl%0d_chk_char", i), chk_char, tbl[i].x_chk);
      check($sformatf("tbl%0d_res_valid", i), 8'(res_valid), 8'(tbl[i].x_rv));
      check($sformatf("tbl%0d_res_fields", i), {1'b0, res_chan, res_format_type, res_error_code},
            {1'b0, tbl[i].x_rch, tbl[i].x_rf, tbl[i].x_re});
      check($sformatf("tbl%0d_ready", i), {6'd0, in1_ready, in0_ready}, 8'h03);
    end

    // Both channels complete on the same cycle after reset: ch0 first, then ch1
    do_reset();
    cyc(1, "A", 1, "C", 2'b11, 4'hF);
    cyc(1, "B", 1, "D", 2'b11, 4'hF);
    cyc(1, "#", 1, "#", 2'b11, 4'hF);
    exp_s = '{IDLE, "A", "B", "#", IDLE, IDLE, "C", "D", "#", IDLE, IDLE};
    for (int i = 0; i < 11; i++) begin
      if (i == 4)      cyc(0, 0, 0, 0, 2'b01, 4'h1);
      else if (i == 9) cyc(0, 0, 0, 0, 2'b10, 4'h2);
      else             idle_cyc();
      check($sformatf("dual%0d_chk_char", i), chk_char, exp_s[i]);
      check($sformatf("dual%0d_res_valid", i), 8'(res_valid), 8'((i == 5) || (i == 10)));
      if (i == 5)  check("dual_res0", {1'b0, res_chan, res_format_type, res_error_code}, {1'b0, 1'b0, 2'b01, 4'h1});
      if (i == 10) check("dual_res1", {1'b0, res_chan, res_format_type, res_error_code}, {1'b0, 1'b1, 2'b10, 4'h2});
    end

    // Ch1 half message stalls 20 cycles while ch0 sends a complete one
    cyc(0, 0, 1, "p", 2'b11, 4'hF);
    cyc(0, 0, 1, "q", 2'b11, 4'hF);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] xc;
      if (i == 0)      cyc(1, "r", 0, 0, 2'b11, 4'hF);
      else if (i == 1) cyc(1, "#", 0, 0, 2'b11, 4'hF);
      else if (i == 5) cyc(0, 0, 0, 0, 2'b01, 4'h4);
      else             idle_cyc();
      xc = (i == 3) ? 8'h72 : (i == 4) ? 8'h23 : IDLE;
      check($sformatf("stall%0d_chk_char", i), chk_char, xc);
      check($sformatf("stall%0d_res_valid", i), 8'(res_valid), 8'(i == 6));
      if (i == 6) check("stall_res0", {1'b0, res_chan, res_format_type, res_error_code}, {1'b0, 1'b0, 2'b01, 4'h4});
    end
    cyc(0, 0, 1, "s", 2'b11, 4'hF);
    check("stall_s_chk_char", chk_char, IDLE);
    cyc(0, 0, 1, "#", 2'b11, 4'hF);
    check("stall_h_chk_char", chk_char, IDLE);
    exp_s = '{IDLE, "p", "q", "s", "#", IDLE, IDLE, IDLE, IDLE, IDLE, IDLE};
    for (int i = 0; i < 7; i++) begin
      if (i == 5) cyc(0, 0, 0, 0, 2'b10, 4'h6);
      else        idle_cyc();
      check($sformatf("ch1msg%0d_chk_char", i), chk_char, exp_s[i]);
      check($sformatf("ch1msg%0d_res_valid", i), 8'(res_valid), 8'(i == 6));
    end
    check("ch1msg_res", {1'b0, res_chan, res_format_type, res_error_code}, {1'b0, 1'b1, 2'b10, 4'h6});

    // Overflow: 64 characters with no '#' on ch0
    for (int i = 0; i < 64; i++) cyc(1, "z", 0, 0, 2'b11, 4'hF);
    check("ovf_ready_before_full", 8'(in0_ready), 8'h01);
    cyc(1, "z", 0, 0, 2'b11, 4'hF);
    check("ovf_full_ready", 8'(in0_ready), 8'h00);
    check("ovf_full_ovf0", 8'(ovf0), 8'h00);
    idle_cyc();
    check("ovf_pulse", {6'd0, ovf1, ovf0}, 8'h01);
    check("ovf_ready_after", 8'(in0_ready), 8'h01);
    idle_cyc();
    check("ovf_pulse_end", 8'(ovf0), 8'h00);
    cyc(1, "o", 0, 0, 2'b11, 4'hF);
    cyc(1, "k", 0, 0, 2'b11, 4'hF);
    cyc(1, "#", 0, 0, 2'b11, 4'hF);
    exp_s = '{IDLE, "o", "k", "#", IDLE, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE};
    for (int i = 0; i < 6; i++) begin
      if (i == 4) cyc(0, 0, 0, 0, 2'b01, 4'h0);
      else        idle_cyc();
      check($sformatf("postovf%0d_chk_char", i), chk_char, exp_s[i]);
      check($sformatf("postovf%0d_res_valid", i), 8'(res_valid), 8'(i == 5));
    end

    // Full-length trace line on ch0: result L+2 cycles after the grant cycle
    msg = "^10@00003000: $1 <= 00000001#";
    for (int i = 0; i < msg.len(); i++) cyc(1, msg[i], 0, 0, 2'b11, 4'hF);
    idle_cyc();
    check("trace_grant_cycle", chk_char, IDLE);
    for (int i = 0; i < msg.len(); i++) begin
      idle_cyc();
      check($sformatf("trace_char%0d", i), chk_char, msg[i]);
    end
    cyc(0, 0, 0, 0, 2'b01, 4'h0);
    check("trace_wait_chk_char", chk_char, IDLE);
    check("trace_wait_res_valid", 8'(res_valid), 8'h00);
    idle_cyc();
    check("trace_res_valid", 8'(res_valid), 8'h01);
    check("trace_res", {1'b0, res_chan, res_format_type, res_error_code}, {1'b0, 1'b0, 2'b01, 4'h0});

    // Reset asserted mid-message abandons it without a result
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 8'h61 + 8'(i == 6 ? 8'hC2 : 8'(i)), 2'b11, 4'hF);
    idle_cyc();
    idle_cyc();
    check("rstsend_char_a", chk_char, "a");
    idle_cyc();
    check("rstsend_char_b", chk_char, "b");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rstsend_chk_char", chk_char, IDLE);
    check("rstsend_res_valid", 8'(res_valid), 8'h00);
    check("rstsend_ready", {6'd0, in1_ready, in0_ready}, 8'h03);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      idle_cyc();
      check($sformatf("rstsend_after%0d_chk_char", i), chk_char, IDLE);
      check($sformatf("rstsend_after%0d_res_valid", i), 8'(res_valid), 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
